// File: rtl/pixel_mux.sv
// rtl/pixel_mux.sv - NES-style background/sprite pixel priority mux with palette lookup and sprite-0 hit.
// Optional macro PIXMUX_GRAYSCALE_EN masks the output color to its luma bits when grayscale is set.
module pixel_mux #(
  parameter int LEFT_CLIP_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic [7:0]  x,
  input  logic [3:0]  bg_pix,
  input  logic [3:0]  spr_pix,
  input  logic        spr_pri,
  input  logic        spr0,
  input  logic        show_bg,
  input  logic        show_spr,
  input  logic        show_bg_left,
  input  logic        show_spr_left,
  input  logic        rendering,
  input  logic [13:0] vaddr,
  input  logic        grayscale,
  input  logic        frame_start,
  output logic [4:0]  pal_addr,
  input  logic [7:0]  pal_data,
  output logic [5:0]  color_o,
  output logic        color_valid,
  output logic        spr0_hit
);

  logic [4:0] r_pal_addr;
  logic [5:0] r_color;
  logic [2:0] r_valid;
  logic       r_spr0_hit;

  logic       w_in_clip;
  logic       w_bg_opaque;
  logic       w_spr_opaque;
  logic       w_hit;
  logic [4:0] w_sel_addr;
  logic [5:0] w_color_next;
  logic       w_unused;

  always_comb begin
    w_in_clip    = ({24'd0, x} < LEFT_CLIP_W);
    w_bg_opaque  = (bg_pix[1:0] != 2'd0) && show_bg && !(w_in_clip && !show_bg_left);
    w_spr_opaque = (spr_pix[1:0] != 2'd0) && show_spr && !(w_in_clip && !show_spr_left);
    w_hit        = rendering && spr0 && w_bg_opaque && w_spr_opaque && (x != 8'd255);
    w_sel_addr   = 5'h00;
    // Outside rendering the CPU's VRAM pointer exposes the palette directly.
    if (!rendering) begin
      if (vaddr[13:8] == 6'h3F) begin
        w_sel_addr = vaddr[4:0];
      end
    end else if (w_spr_opaque && (!w_bg_opaque || !spr_pri)) begin
      w_sel_addr = {1'b1, spr_pix};
    end else if (w_bg_opaque) begin
      w_sel_addr = {1'b0, bg_pix};
    end
  end

`ifdef PIXMUX_GRAYSCALE_EN
  assign w_color_next = grayscale ? (pal_data[5:0] & 6'h30) : pal_data[5:0];
`else
  assign w_color_next = pal_data[5:0];
`endif

  assign w_unused = &{1'b0, grayscale, pal_data[7:6], vaddr[7:5]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pal_addr <= 5'h00;
      r_color    <= 6'h00;
      r_valid    <= 3'b000;
      r_spr0_hit <= 1'b0;
    end else begin
      r_valid <= {r_valid[1:0], pix_valid};
      if (pix_valid) begin
        r_pal_addr <= w_sel_addr;
      end
      // r_valid[1] marks the cycle where palette RAM data for our address is present.
      if (r_valid[1]) begin
        r_color <= w_color_next;
      end
      if (frame_start) begin
        r_spr0_hit <= 1'b0;
      end else if (pix_valid && w_hit) begin
        r_spr0_hit <= 1'b1;
      end
    end
  end

  assign pal_addr    = r_pal_addr;
  assign color_o     = r_color;
  assign color_valid = r_valid[2];
  assign spr0_hit    = r_spr0_hit;

endmodule

// File: tb/tb_pixel_mux.sv
// tb/tb_pixel_mux.sv - self-checking bench for pixel_mux with random stimulus and a priority-rule reference model.
module tb_pixel_mux;

  localparam int CLIP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  x = 8'd0;
  logic [3:0]  bg_pix = 4'd0;
  logic [3:0]  spr_pix = 4'd0;
  logic        spr_pri = 1'b0;
  logic        spr0 = 1'b0;
  logic        show_bg = 1'b0;
  logic        show_spr = 1'b0;
  logic        show_bg_left = 1'b0;
  logic        show_spr_left = 1'b0;
  logic        rendering = 1'b0;
  logic [13:0] vaddr = 14'd0;
  logic        grayscale = 1'b0;
  logic        frame_start = 1'b0;
  logic [4:0]  pal_addr;
  logic [7:0]  pal_data = 8'd0;
  logic [5:0]  color_o;
  logic        color_valid;
  logic        spr0_hit;

  pixel_mux #(.LEFT_CLIP_W(CLIP)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .x(x), .bg_pix(bg_pix),
    .spr_pix(spr_pix), .spr_pri(spr_pri), .spr0(spr0), .show_bg(show_bg),
    .show_spr(show_spr), .show_bg_left(show_bg_left), .show_spr_left(show_spr_left),
    .rendering(rendering), .vaddr(vaddr), .grayscale(grayscale),
    .frame_start(frame_start), .pal_addr(pal_addr), .pal_data(pal_data),
    .color_o(color_o), .color_valid(color_valid), .spr0_hit(spr0_hit)
  );

  always #5 clk = ~clk;

  // External palette RAM: registered read, one cycle after the address.
  logic [7:0] pal_ram [32];
  always @(posedge clk) pal_data <= pal_ram[pal_addr];

  typedef struct {
    int         due;
    logic [4:0] addr;
  } pend_t;

  pend_t      pend[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [4:0] exp_addr = 5'h00;
  logic       exp_hit = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit bg_visible();
    return (bg_pix[1:0] != 0) && show_bg && (x >= CLIP || show_bg_left);
  endfunction

  function automatic bit spr_visible();
    return (spr_pix[1:0] != 0) && show_spr && (x >= CLIP || show_spr_left);
  endfunction

  function automatic logic [4:0] ref_addr();
    bit b = bg_visible();
    bit s = spr_visible();
    if (!rendering) return (vaddr[13:8] == 6'h3F) ? vaddr[4:0] : 5'h00;
    if (b && s) return spr_pri ? {1'b0, bg_pix} : {1'b1, spr_pix};
    if (s) return {1'b1, spr_pix};
    if (b) return {1'b0, bg_pix};
    return 5'h00;
  endfunction

  function automatic logic [5:0] ref_color(input logic [4:0] a, input logic g);
    logic [5:0] c = pal_ram[a][5:0];
`ifdef PIXMUX_GRAYSCALE_EN
    if (g) c = c & 6'h30;
`endif
    return c;
  endfunction

  // One clock: model predicts from the inputs held across the edge, then the outputs are compared.
  task automatic step();
    logic [4:0] a  = ref_addr();
    bit         h  = rendering && spr0 && bg_visible() && spr_visible() && (x != 8'd255);
    bit         pv = pix_valid;
    bit         fs = frame_start;
    logic       g  = grayscale;
    bit         ev = 1'b0;
    logic [5:0] ec = 6'h00;
    @(posedge clk);
    #1;
    if (pv) begin
      exp_addr = a;
      pend.push_back('{due: cyc + 2, addr: a});
    end
    if (fs) exp_hit = 1'b0;
    else if (pv && h) exp_hit = 1'b1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = 1'b1;
      ec = ref_color(pend[0].addr, g);
      void'(pend.pop_front());
    end
    check("pal_addr", pal_addr, exp_addr);
    check("spr0_hit", spr0_hit, exp_hit);
    check("color_valid", color_valid, ev);
    if (ev) check("color_o", color_o, ec);
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, pal_addr, 0);
    check({tag, "_color"}, color_o, 0);
    check({tag, "_valid"}, color_valid, 0);
    check({tag, "_hit"}, spr0_hit, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_all_zero("rst_async");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    cyc++;
    rst = 1'b0;
    pend.delete();
    exp_addr = 5'h00;
    exp_hit = 1'b0;
  endtask

  task automatic set_px(input logic [3:0] b, input logic [3:0] s, input logic pri,
                        input logic s0, input logic [7:0] xx);
    pix_valid = 1'b1;
    bg_pix = b;
    spr_pix = s;
    spr_pri = pri;
    spr0 = s0;
    x = xx;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) pal_ram[i] = 8'($urandom);
    pal_ram[5'h01] = 8'h2A;
    #2;
    do_reset();
    rendering = 1'b1;
    show_bg = 1'b1;
    show_spr = 1'b1;
    show_bg_left = 1'b1;
    show_spr_left = 1'b1;

    set_px(4'h6, 4'h9, 1'b0, 1'b0, 8'd20);
    step();
    check("req17_addr", pal_addr, 5'h19);
    pix_valid = 1'b0;
    step();
    step();
    check("req17_valid", color_valid, 1);
    check("req17_color", color_o, pal_ram[5'h19][5:0]);

    set_px(4'h6, 4'h9, 1'b1, 1'b0, 8'd20);
    step();
    check("req18_pri", pal_addr, 5'h06);
    set_px(4'h4, 4'h9, 1'b1, 1'b0, 8'd20);
    step();
    check("req18_bgclear", pal_addr, 5'h19);

    show_bg_left = 1'b0;
    set_px(4'h7, 4'h0, 1'b0, 1'b0, 8'd3);
    step();
    check("req19_clip", pal_addr, 5'h00);
    set_px(4'h7, 4'h9, 1'b0, 1'b1, 8'd3);
    step();
    check("req19_nohit", spr0_hit, 0);
    show_bg_left = 1'b1;

    set_px(4'h6, 4'h9, 1'b1, 1'b1, 8'd100);
    step();
    check("req20_hit", spr0_hit, 1);
    pix_valid = 1'b0;
    spr0 = 1'b0;
    repeat (3) step();
    check("req20_sticky", spr0_hit, 1);
    frame_start = 1'b1;
    set_px(4'h6, 4'h9, 1'b0, 1'b1, 8'd100);
    step();
    check("req20_clearwins", spr0_hit, 0);
    frame_start = 1'b0;
    set_px(4'h6, 4'h9, 1'b0, 1'b1, 8'd255);
    step();
    check("req20_x255", spr0_hit, 0);
    spr0 = 1'b0;

    rendering = 1'b0;
    pix_valid = 1'b1;
    vaddr = 14'h3F0B;
    step();
    check("req21_pal", pal_addr, 5'h0B);
    vaddr = 14'h2000;
    step();
    check("req21_nonpal", pal_addr, 5'h00);
    rendering = 1'b1;

    grayscale = 1'b1;
    set_px(4'h1, 4'h0, 1'b0, 1'b0, 8'd50);
    step();
    pix_valid = 1'b0;
    step();
    step();
`ifdef PIXMUX_GRAYSCALE_EN
    check("req22_gray", color_o, 6'h20);
`else
    check("req22_nogray", color_o, 6'h2A);
`endif
    grayscale = 1'b0;

    set_px(4'h5, 4'hA, 1'b0, 1'b0, 8'd60);
    step();
    step();
    do_reset();
    pix_valid = 1'b0;
    repeat (4) step();
    check("req22_nostale", color_valid, 0);

    for (int i = 0; i < 1500; i++) begin
      pix_valid     = ($urandom_range(0, 3) != 0);
      x             = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) :
                      (($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom));
      bg_pix        = 4'($urandom);
      spr_pix       = 4'($urandom);
      spr_pri       = 1'($urandom);
      spr0          = ($urandom_range(0, 2) == 0);
      show_bg       = ($urandom_range(0, 7) != 0);
      show_spr      = ($urandom_range(0, 7) != 0);
      show_bg_left  = 1'($urandom);
      show_spr_left = 1'($urandom);
      rendering     = ($urandom_range(0, 6) != 0);
      vaddr         = 1'($urandom) ? {6'h3F, 8'($urandom)} : 14'($urandom);
      grayscale     = 1'($urandom);
      frame_start   = ($urandom_range(0, 19) == 0);
      if (i == 700) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
